// File: rtl/weight_fifo_loader.sv
// Write-side sequencer for the 3-column weight FIFO: fetches a 3x3 tile from weight memory,
// pushes it into the column queues, then issues the pop train that feeds the systolic MMU.
module weight_fifo_loader #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned POP_CYCLES   = 7,
    parameter int unsigned REVERSE_ROWS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rd_data,
    output logic              weight_load_start,
    output logic              push_col0,
    output logic              push_col1,
    output logic              push_col2,
    output logic [7:0]        data_col0,
    output logic [7:0]        data_col1,
    output logic [7:0]        data_col2,
    output logic              pop,
    output logic              mmu_load_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PopW = $clog2(POP_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StWait,
        StPop,
        StDone
    } state_e;

    state_e                state_q;
    logic [ADDR_W-1:0]     base_q;
    logic [1:0]            rd_cnt_q;
    logic [1:0]            push_cnt_q;
    logic [PopW-1:0]       pop_cnt_q;
    logic [RD_LATENCY-1:0] vld_q;
    logic                  rd_issue;
    logic [1:0]            row_off;

    // A read is launched in CLEAR (row 0) and in FETCH until three have gone out.
    always_comb begin
        rd_issue = (state_q == StClear) || ((state_q == StFetch) && (rd_cnt_q != 2'd3));
        row_off  = (REVERSE_ROWS != 0) ? (2'd2 - rd_cnt_q) : rd_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            base_q            <= '0;
            rd_cnt_q          <= '0;
            push_cnt_q        <= '0;
            pop_cnt_q         <= '0;
            vld_q             <= '0;
            mem_rd_en         <= 1'b0;
            mem_addr          <= '0;
            weight_load_start <= 1'b0;
            push_col0         <= 1'b0;
            push_col1         <= 1'b0;
            push_col2         <= 1'b0;
            data_col0         <= '0;
            data_col1         <= '0;
            data_col2         <= '0;
            pop               <= 1'b0;
            mmu_load_en       <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            weight_load_start <= 1'b0;
            mem_rd_en         <= rd_issue;
            pop               <= 1'b0;
            mmu_load_en       <= 1'b0;
            done              <= 1'b0;
            push_col0         <= vld_q[RD_LATENCY-1];
            push_col1         <= vld_q[RD_LATENCY-1];
            push_col2         <= vld_q[RD_LATENCY-1];

            // Valid tag travels with each read so the push lines up with its data.
            vld_q[0] <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end

            if (rd_issue) begin
                mem_addr <= base_q + ADDR_W'(row_off);
                rd_cnt_q <= rd_cnt_q + 2'd1;
            end

            if (vld_q[RD_LATENCY-1]) begin
                data_col0  <= mem_rd_data[7:0];
                data_col1  <= mem_rd_data[15:8];
                data_col2  <= mem_rd_data[23:16];
                push_cnt_q <= push_cnt_q + 2'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q            <= base_addr;
                        rd_cnt_q          <= '0;
                        push_cnt_q        <= '0;
                        pop_cnt_q         <= '0;
                        weight_load_start <= 1'b1;
                        busy              <= 1'b1;
                        state_q           <= StClear;
                    end
                end
                StClear: state_q <= StFetch;
                StFetch: begin
                    if (rd_cnt_q == 2'd3) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (push_cnt_q == 2'd3) begin
                        pop         <= 1'b1;
                        mmu_load_en <= 1'b1;
                        pop_cnt_q   <= PopW'(1);
                        state_q     <= StPop;
                    end
                end
                StPop: begin
                    if (pop_cnt_q == PopW'(POP_CYCLES)) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        pop         <= 1'b1;
                        mmu_load_en <= 1'b1;
                        pop_cnt_q   <= pop_cnt_q + PopW'(1);
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Scoreboard bench for weight_fifo_loader: three instances cover RD_LATENCY 1/3 and both row orders.
module tb_weight_fifo_loader;

    typedef struct {
        int          cyc;
        int          kind;
        logic [23:0] val;
    } ev_t;

    localparam int KWls = 0, KRd = 1, KPush = 2, KPop = 3, KDone = 4;

    logic        clk = 1'b0;
    logic [2:0]  rst, start;
    logic [7:0]  base [3];
    logic [2:0]  mem_rd_en, wls, push0, push1, push2, pop, mle, busy, done;
    logic [7:0]  mem_addr [3];
    logic [7:0]  d0 [3], d1 [3], d2 [3];
    logic [23:0] rdata [3];
    logic [23:0] mem [256];

    ev_t         exp_q [3][$];
    logic [23:0] exp_last [3];
    int          b_lo [3], b_hi [3], rst_cyc [3];
    int          cyc = 0;
    int          checks = 0, errors = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Lat = (g == 1) ? 3 : 1;
        localparam int unsigned Rev = (g == 2) ? 0 : 1;
        logic [7:0] apipe [2];

        always @(posedge clk) begin
            apipe[0] <= mem_addr[g];
            apipe[1] <= apipe[0];
        end

        if (Lat == 1) begin : g_l1
            assign rdata[g] = mem[mem_addr[g]];
        end else begin : g_ln
            assign rdata[g] = mem[apipe[Lat-2]];
        end

        weight_fifo_loader #(
            .ADDR_W      (8),
            .RD_LATENCY  (Lat),
            .POP_CYCLES  (7),
            .REVERSE_ROWS(Rev)
        ) u_dut (
            .clk              (clk),
            .rst              (rst[g]),
            .start            (start[g]),
            .base_addr        (base[g]),
            .mem_rd_en        (mem_rd_en[g]),
            .mem_addr         (mem_addr[g]),
            .mem_rd_data      (rdata[g]),
            .weight_load_start(wls[g]),
            .push_col0        (push0[g]),
            .push_col1        (push1[g]),
            .push_col2        (push2[g]),
            .data_col0        (d0[g]),
            .data_col1        (d1[g]),
            .data_col2        (d2[g]),
            .pop              (pop[g]),
            .mmu_load_en      (mle[g]),
            .busy             (busy[g]),
            .done             (done[g])
        );
    end

    function automatic string kname(int k);
        case (k)
            KWls:    return "weight_load_start";
            KRd:     return "read";
            KPush:   return "push";
            KPop:    return "pop";
            default: return "done";
        endcase
    endfunction

    task automatic check(bit ok, string name, int i, logic [23:0] act, logic [23:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %06h, expected %06h", name, i, cyc, act, req);
        end
    endtask

    task automatic observe(int i, int kind, logic act, logic [23:0] val);
        ev_t e;
        if (exp_q[i].size() > 0 && exp_q[i][0].cyc == cyc && exp_q[i][0].kind == kind) begin
            e = exp_q[i].pop_front();
            check(act === 1'b1, {kname(kind), "_missing"}, i, {23'd0, act}, 24'd1);
            if (act === 1'b1) check(val === e.val, {kname(kind), "_value"}, i, val, e.val);
            if (kind == KPush) exp_last[i] = e.val;
        end else if (act !== 1'b0) begin
            check(1'b0, {kname(kind), "_unexpected"}, i, {23'd0, act}, 24'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
                    check(1'b0, {kname(exp_q[i][0].kind), "_stale"}, i, 24'd0, exp_q[i][0].val);
                    void'(exp_q[i].pop_front());
                end
                if (rst_cyc[i] >= 0 && cyc == rst_cyc[i] + 1) begin
                    check({wls[i], mem_rd_en[i], push0[i], push1[i], push2[i], pop[i], mle[i],
                           busy[i], done[i]} == 9'd0 && {mem_addr[i], d2[i], d1[i], d0[i]} == 32'd0,
                          "mid_reset_zero", i, {15'd0, wls[i], mem_rd_en[i], push0[i], pop[i],
                          mle[i], busy[i], done[i], mem_addr[i]}, 24'd0);
                    exp_last[i] = 24'd0;
                    rst_cyc[i]  = -1;
                end
                observe(i, KWls, wls[i], 24'd0);
                observe(i, KRd, mem_rd_en[i], {16'd0, mem_addr[i]});
                observe(i, KPush, push0[i], {d2[i], d1[i], d0[i]});
                observe(i, KPop, pop[i], 24'd0);
                observe(i, KDone, done[i], 24'd0);
                check(push1[i] == push0[i] && push2[i] == push0[i], "push_cols_aligned", i,
                      {21'd0, push2[i], push1[i], push0[i]}, {21'd0, {3{push0[i]}}});
                check(!(push0[i] && pop[i]), "push_pop_overlap", i, {23'd0, pop[i]}, 24'd0);
                check(!(wls[i] && (push0[i] || pop[i])), "wls_overlap", i,
                      {22'd0, push0[i], pop[i]}, 24'd0);
                check(mle[i] == pop[i], "mmu_load_en", i, {23'd0, mle[i]}, {23'd0, pop[i]});
                check(busy[i] == (cyc >= b_lo[i] && cyc <= b_hi[i]), "busy", i, {23'd0, busy[i]},
                      {23'd0, (cyc >= b_lo[i] && cyc <= b_hi[i])});
                if (!push0[i]) check({d2[i], d1[i], d0[i]} == exp_last[i], "data_hold", i,
                                     {d2[i], d1[i], d0[i]}, exp_last[i]);
            end
        end
    end

    // One tile on instance i; a0..a2 are the hand-computed read addresses in issue order.
    task automatic run(int i, logic [7:0] b, logic [7:0] a0, logic [7:0] a1, logic [7:0] a2,
                       int lat, bit ign, int rst_at);
        int          t;
        int          last;
        logic [7:0]  ad [3];
        ev_t         e;
        ad = '{a0, a1, a2};
        @(posedge clk); #1;
        t = cyc;
        start[i] = 1'b1;
        base[i]  = b;
        last = 5 + lat + 7;
        for (int c = 1; c <= last; c++) begin
            for (int k = 0; k < 5; k++) begin
                e.cyc = t + c;
                e.kind = k;
                e.val = 24'd0;
                if (k == KWls && c == 1) exp_q[i].push_back(e);
                for (int r = 0; r < 3; r++) begin
                    if (k == KRd && c == 2 + r) begin
                        e.val = {16'd0, ad[r]};
                        exp_q[i].push_back(e);
                    end
                    if (k == KPush && c == 2 + lat + r) begin
                        e.val = mem[ad[r]];
                        exp_q[i].push_back(e);
                    end
                end
                if (k == KPop && c >= 5 + lat && c < last) exp_q[i].push_back(e);
                if (k == KDone && c == last) exp_q[i].push_back(e);
            end
        end
        b_lo[i] = t + 1;
        b_hi[i] = t + last - 1;
        for (int r = 1; r <= last + 3; r++) begin
            @(posedge clk); #1;
            start[i] = ign && (r == 4 || r == last);
            base[i]  = 8'h40;
            rst[i]   = (r == rst_at);
            if (r == rst_at) begin
                rst_cyc[i] = t + r;
                b_hi[i] = t + r;
                while (exp_q[i].size() > 0 && exp_q[i][$].cyc > t + r) void'(exp_q[i].pop_back());
            end
        end
        rst[i]   = 1'b0;
        start[i] = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = {8'(a) ^ 8'h3C, 8'(a) ^ 8'hC3, 8'(a)};
        mem[8'h10] = 24'h030201;
        mem[8'h11] = 24'h060504;
        mem[8'h12] = 24'h090807;
        for (int i = 0; i < 3; i++) begin
            base[i] = 8'h00;
            exp_last[i] = 24'd0;
            b_lo[i] = -1;
            b_hi[i] = -2;
            rst_cyc[i] = -1;
        end
        rst   = 3'b111;
        start = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check({wls[i], mem_rd_en[i], push0[i], push1[i], push2[i], pop[i], mle[i], busy[i],
                   done[i]} == 9'd0, "reset_strobes", i,
                  {15'd0, wls[i], mem_rd_en[i], push0[i], push1[i], push2[i], pop[i], mle[i],
                   busy[i], done[i]}, 24'd0);
            check({mem_addr[i], d2[i], d1[i], d0[i]} == 32'd0, "reset_data", i,
                  {d2[i], d1[i], d0[i]}, 24'd0);
        end
        @(posedge clk); #1;
        rst    = 3'b000;
        mon_en = 1'b1;

        run(0, 8'h10, 8'h12, 8'h11, 8'h10, 1, 1'b1, -1);  // basic tile + ignored starts
        run(0, 8'hFF, 8'h01, 8'h00, 8'hFF, 1, 1'b0, 7);   // wrap, reset during POP
        run(0, 8'h20, 8'h22, 8'h21, 8'h20, 1, 1'b0, -1);  // fresh start after reset
        run(1, 8'h10, 8'h12, 8'h11, 8'h10, 3, 1'b0, -1);  // RD_LATENCY=3
        run(2, 8'hFE, 8'hFE, 8'hFF, 8'h00, 1, 1'b0, -1);  // forward order, wrap

        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check(exp_q[i].size() == 0, "queue_drained", i, 24'(exp_q[i].size()), 24'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_fifo_loader.md
Name: weight_fifo_loader

Overview:
- Write-side sequencer for the 3-column weight FIFO that feeds the 3x3 systolic MMU.
- On a start command it reads a 3x3 weight tile (one 24-bit row per word) from weight memory and pushes it into the three column queues.
- It then issues the pop train that drives the skewed diagonal wavefront into the MMU.
- It is the initiator for the FIFO's push/pop/weight_load_start interface; it sits between the controller and the FIFO.

Parameters:
ADDR_W, 8, weight-memory address width
RD_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (1..3)
POP_CYCLES, 7, pops issued per tile (rows plus skew flush)
REVERSE_ROWS, 1, 1: fetch rows base+2, base+1, base+0; 0: fetch base+0, base+1, base+2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle command; sampled only in IDLE
base_addr  in  ADDR_W  tile base address; captured with start
mem_rd_en  out  1  weight-memory read strobe
mem_addr  out  ADDR_W  weight-memory read address
mem_rd_data  in  24  {col2[23:16], col1[15:8], col0[7:0]}; valid RD_LATENCY cycles after mem_rd_en
weight_load_start  out  1  one-cycle FIFO resync pulse
push_col0/1/2  out  1 each  FIFO column push strobes
data_col0/1/2  out  8 each  FIFO column push data
pop  out  1  FIFO pop strobe
mmu_load_en  out  1  MMU weight-shift enable; identical to pop
busy  out  1  high from CLEAR through the last POP cycle
done  out  1  one-cycle pulse after the final pop

Behaviour:
- Reset: state IDLE. All outputs are 0. Counters, the captured address and the read-valid shift register are cleared.
- Reset mid-operation: abandons the sequence immediately. No further push or pop is issued. done does not pulse.
- All outputs are registered.
- FSM IDLE -> CLEAR:
  - Taken when start=1 in IDLE (call this cycle T).
  - base_addr is captured in cycle T.
- CLEAR:
  - In cycle T+1, weight_load_start=1 and busy=1.
  - No push or pop is issued in this cycle, because the FIFO resets its pointers on this pulse.
- FETCH:
  - Cycles T+2..T+4 assert mem_rd_en with three addresses, one per cycle, in REVERSE_ROWS order.
  - Addresses wrap modulo 2^ADDR_W; base 0xFF with REVERSE_ROWS=1 gives 0x01, 0x00, 0xFF.
- Push alignment:
  - A RD_LATENCY-deep valid shift register tracks outstanding reads.
  - When a read's valid emerges, push_col0/1/2 all assert in the same cycle, with data_col* taken from the mem_rd_data slices.
  - Pushes therefore occur in cycles T+2+RD_LATENCY .. T+4+RD_LATENCY.
- WAIT: entered after the third read. Held until the third push has been issued.
- POP:
  - Starts the cycle after the third push.
  - pop and mmu_load_en are asserted for exactly POP_CYCLES consecutive cycles. No push is issued during POP.
- DONE:
  - In the cycle after the last pop, done=1 and busy=0; the FSM then returns to IDLE.
  - start sampled in the DONE cycle is ignored.
- start while busy is ignored, and base_addr is not recaptured.
- push_col* and pop are never asserted in the same cycle.
- weight_load_start is never coincident with push or pop.
- Total latency from start to done, with RD_LATENCY=1 and POP_CYCLES=7: 13 cycles.
  - done is in cycle T+13.
  - pops are in T+6..T+12.
- data_col* hold their last pushed value when push is low. data_col* are 0 after reset.

Test Plan:
- Basic tile:
  - Stimulus: base=0x10, mem[0x10]=0x030201, mem[0x11]=0x060504, mem[0x12]=0x090807, REVERSE_ROWS=1.
  - Response: reads of 0x12, 0x11, 0x10; pushes of col0 07, 04, 01, col1 08, 05, 02, col2 09, 06, 03; 7 pops in T+6..T+12; done at T+13.
- Handshake spacing:
  - Check that weight_load_start fires only at T+1.
  - Check that no push or pop overlaps it, and that push and pop are never coincident in any cycle.
- Latency parameter: with RD_LATENCY=3, pushes occur at T+5..T+7, pops at T+8..T+14, and done at T+15.
- Address wrap: base=0xFF with REVERSE_ROWS=1 gives addresses 0x01, 0x00, 0xFF. With REVERSE_ROWS=0, base=0xFE gives 0xFE, 0xFF, 0x00.
- Ignored start: pulse start again at T+4 with base 0x40. No address 0x4x is read, the sequence is unchanged, and there is a single done.
- Reset mid-op: assert rst at T+7 (during POP). The next cycle has all outputs 0 and state IDLE, no done pulse. A fresh start then completes normally.
